// File: rtl/mac_seq_acc_pkg.sv
// Shared definitions for the sequential multiply-accumulate stage:
// FSM state encoding and default operand/accumulator widths.
package mac_pkg;

    localparam int MAC_WIDTH = 8;
    localparam int MAC_ACC_W = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } state_t;

endpackage : mac_pkg

// File: rtl/mac_seq_acc_if.sv
// Operand/result bundle between the operand-select muxes and the MAC stage.
//
// Handshake: `start` is a request that is only taken while `busy`=0 (IDLE);
// while `busy`=1 it is ignored and nothing is queued. Once taken, `a`/`b`
// are captured and may change freely. `done` pulses for exactly one cycle
// when the updated `acc` is visible; the same cycle is already IDLE, so a
// `start` held there is taken on the next edge (back-to-back operation).
// `clear_acc` is independent of the handshake and acts on the next edge.
interface mac_seq_acc_if
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH,
    parameter int ACC_W = MAC_ACC_W
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             start;
    logic             clear_acc;
    logic [ACC_W-1:0] acc;
    logic             busy;
    logic             done;
    logic             overflow;

    // Upstream side: drives operands and controls, observes results.
    modport master (
        output a, b, start, clear_acc,
        input  acc, busy, done, overflow
    );

    // MAC side.
    modport slave (
        input  a, b, start, clear_acc,
        output acc, busy, done, overflow
    );

endinterface : mac_seq_acc_if

// File: rtl/mac_acc_add.sv
// ACC_W-bit unsigned adder with carry-out; the carry is the wrap-around
// indication for the accumulator.
module mac_acc_add #(
    parameter int ACC_W = 20
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_carry
);

    logic [ACC_W:0] w_full;

    // One extra bit holds the carry out of bit ACC_W-1.
    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum   = w_full[ACC_W-1:0];
    assign o_carry = w_full[ACC_W];

endmodule : mac_acc_add

// File: rtl/mac_seq_acc.sv
// Sequential unsigned multiply-accumulate: shift-and-add multiply, one
// multiplier bit per cycle, then a single-cycle accumulate with sticky
// overflow. The current FSM state is exported on o_dbg_state.
module mac_seq_acc
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH,
    parameter int ACC_W = MAC_ACC_W   // must be >= 2*WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    mac_seq_acc_if.slave  bus,
    output state_t        o_dbg_state
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    state_t             w_next;

    logic [PW-1:0]      r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [PW-1:0]      r_prod;
    logic [CNT_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_busy;
    logic               r_done;
    logic               r_ovf;

    logic [ACC_W-1:0]   w_add_a;
    logic [ACC_W-1:0]   w_add_b;
    logic [ACC_W-1:0]   w_sum;
    logic               w_carry;

    // A clear in the ACC cycle zeroes the old value before the add, so the
    // product lands in an empty accumulator.
    assign w_add_a = bus.clear_acc ? '0 : r_acc;
    assign w_add_b = ACC_W'(r_prod);

    mac_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .i_a     (w_add_a),
        .i_b     (w_add_b),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: the counter reaching zero ends the WIDTH-cycle multiply.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = MUL;
            MUL:     if (r_cnt == '0) w_next = ACC;
            ACC:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Multiply datapath, registered status flags, accumulator and overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= (r_state == ACC);

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mcand  <= PW'(bus.a);
                        r_mplier <= bus.b;
                        r_prod   <= '0;
                        r_cnt    <= CNT_W'(WIDTH - 1);
                    end
                end
                MUL: begin
                    // Partial product fits in PW bits, so no carry to track.
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - 1'b1;
                end
                default: ;
            endcase

            if (r_state == ACC) begin
                r_acc <= w_sum;
                r_ovf <= (bus.clear_acc ? 1'b0 : r_ovf) | w_carry;
            end else if (bus.clear_acc) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.acc      = r_acc;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.overflow = r_ovf;
    assign o_dbg_state  = r_state;

endmodule : mac_seq_acc

// File: tb/tb_mac_seq_acc.sv
// Directed bench for mac_seq_acc: single op, back-to-back ops, overflow
// wrap, start-while-busy, clear in the ACC cycle, reset mid-multiply.
module tb_mac_seq_acc;
    import mac_pkg::*;

    localparam int W  = 8;
    localparam int AW = 20;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     n_chk;
    int     n_err;

    mac_seq_acc_if #(.WIDTH(W), .ACC_W(AW)) mif ();

    mac_seq_acc #(
        .WIDTH (W),
        .ACC_W (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (mif.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        mif.clear_acc = 1'b1;
        step();
        mif.clear_acc = 1'b0;
    endtask

    // Issue one start; returns cycles until done and the busy-high count.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output int busy_cycles);
        mif.a     = av;
        mif.b     = bv;
        mif.start = 1'b1;
        step();
        mif.start   = 1'b0;
        lat         = 0;
        busy_cycles = mif.busy ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (mif.done) break;
            if (mif.busy) busy_cycles++;
        end
        if (!mif.done) check("op_timeout", 32'(lat), 32'd9);
    endtask

    initial begin
        int lat;
        int bc;
        int dn;
        n_chk = 0;
        n_err = 0;
        rst           = 1'b1;
        mif.a         = '0;
        mif.b         = '0;
        mif.start     = 1'b0;
        mif.clear_acc = 1'b0;
        step();
        step();
        check("rst_acc",   32'(mif.acc), 32'd0);
        check("rst_busy",  32'(mif.busy), 32'd0);
        check("rst_done",  32'(mif.done), 32'd0);
        check("rst_ovf",   32'(mif.overflow), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        step();

        // 3*5
        run_op(8'd3, 8'd5, lat, bc);
        check("t1_latency", 32'(lat), 32'd9);
        check("t1_busy_cyc", 32'(bc), 32'd9);
        check("t1_acc", 32'(mif.acc), 32'd15);
        check("t1_ovf", 32'(mif.overflow), 32'd0);
        check("t1_busy_at_done", 32'(mif.busy), 32'd0);
        step();
        check("t1_done_pulse", 32'(mif.done), 32'd0);
        check("t1_acc_hold", 32'(mif.acc), 32'd15);

        // back-to-back 255*255, second start in the done cycle
        do_clear();
        check("t2_clear", 32'(mif.acc), 32'd0);
        run_op(8'd255, 8'd255, lat, bc);
        check("t2_acc1", 32'(mif.acc), 32'd65025);
        run_op(8'd255, 8'd255, lat, bc);
        check("t2_latency2", 32'(lat), 32'd9);
        check("t2_acc2", 32'(mif.acc), 32'd130050);

        // 17 accumulations of 255*255 wrap a 20-bit accumulator
        do_clear();
        for (int i = 0; i < 16; i++) run_op(8'd255, 8'd255, lat, bc);
        check("t3_acc16", 32'(mif.acc), 32'd1040400);
        check("t3_ovf16", 32'(mif.overflow), 32'd0);
        run_op(8'd255, 8'd255, lat, bc);
        check("t3_acc17", 32'(mif.acc), 32'd56849);
        check("t3_ovf17", 32'(mif.overflow), 32'd1);
        run_op(8'd255, 8'd255, lat, bc);
        check("t3_acc18", 32'(mif.acc), 32'd121874);
        check("t3_ovf_sticky", 32'(mif.overflow), 32'd1);
        do_clear();
        check("t3_clr_acc", 32'(mif.acc), 32'd0);
        check("t3_clr_ovf", 32'(mif.overflow), 32'd0);

        // start held while busy, operands changed mid-operation
        mif.a     = 8'd12;
        mif.b     = 8'd10;
        mif.start = 1'b1;
        step();
        mif.a = 8'd200;
        mif.b = 8'd77;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mif.done) dn++;
        end
        mif.start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            step();
            if (mif.done) dn++;
        end
        check("t4_done_count", 32'(dn), 32'd1);
        check("t4_acc", 32'(mif.acc), 32'd120);

        // clear_acc in the ACC cycle: old 500 dropped, 7*9 added to zero
        do_clear();
        run_op(8'd20, 8'd25, lat, bc);
        check("t5_acc500", 32'(mif.acc), 32'd500);
        mif.a     = 8'd7;
        mif.b     = 8'd9;
        mif.start = 1'b1;
        step();
        mif.start = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("t5_in_acc", 32'(dbg_state), 32'(ACC));
        check("t5_acc_pre", 32'(mif.acc), 32'd500);
        mif.clear_acc = 1'b1;
        step();
        mif.clear_acc = 1'b0;
        check("t5_done", 32'(mif.done), 32'd1);
        check("t5_acc", 32'(mif.acc), 32'd63);
        check("t5_ovf", 32'(mif.overflow), 32'd0);

        // reset during MUL aborts immediately, no done
        mif.a     = 8'd3;
        mif.b     = 8'd3;
        mif.start = 1'b1;
        step();
        mif.start = 1'b0;
        step();
        step();
        step();
        check("t6_mul_state", 32'(dbg_state), 32'(MUL));
        rst = 1'b1;
        #1;
        check("t6_rst_acc",  32'(mif.acc), 32'd0);
        check("t6_rst_busy", 32'(mif.busy), 32'd0);
        check("t6_rst_done", 32'(mif.done), 32'd0);
        check("t6_rst_ovf",  32'(mif.overflow), 32'd0);
        step();
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (mif.done) dn++;
        end
        check("t6_no_done", 32'(dn), 32'd0);
        run_op(8'd2, 8'd0, lat, bc);
        check("t6_latency", 32'(lat), 32'd9);
        check("t6_acc", 32'(mif.acc), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_mac_seq_acc
